ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch_if.sv | 25 ++
 rtl/ifetch.sv | 166 ++++++++++++++++
 tb/tb_ifetch.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_if.sv
// Fetch-unit bus bundle: redirect input, ROM request/response channel and instruction output handshake.
// The master modport is the fetch unit; the slave modport is the ROM/consumer environment.
interface ifetch_if;
  logic        redirect_i;
  logic [15:0] redirect_addr_i;
  logic        rom_req_o;
  logic [15:0] rom_addr_o;
  logic        rom_gnt_i;
  logic        rom_rvalid_i;
  logic [15:0] rom_rdata_i;
  logic        instr_valid_o;
  logic [15:0] instr_o;
  logic [15:0] instr_pc_o;
  logic        instr_ready_i;

  modport master (
    input  redirect_i, redirect_addr_i, rom_gnt_i, rom_rvalid_i, rom_rdata_i, instr_ready_i,
    output rom_req_o, rom_addr_o, instr_valid_o, instr_o, instr_pc_o
  );

  modport slave (
    output redirect_i, redirect_addr_i, rom_gnt_i, rom_rvalid_i, rom_rdata_i, instr_ready_i,
    input  rom_req_o, rom_addr_o, instr_valid_o, instr_o, instr_pc_o
  );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch unit: issues in-order ROM reads, buffers responses in a small FIFO,
// and squashes stale responses after a redirect. A protocol checker sits alongside.
module ifetch_sva #(
  parameter int unsigned DEPTH = 2
) (
  input logic        clk_i,
  input logic        reset_n_i,
  input logic        rom_req_i,
  input logic        rom_gnt_i,
  input logic        rom_rvalid_i,
  input logic [15:0] rom_addr_i,
  input logic [2:0]  in_flight_i,
  input logic [2:0]  fifo_count_i
);
  a_gnt_needs_req: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    rom_gnt_i |-> rom_req_i)
    else $error("rom_gnt_i asserted while rom_req_o is low");

  a_rvalid_needs_inflight: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    rom_rvalid_i |-> (in_flight_i != 3'd0))
    else $error("rom_rvalid_i asserted with no request in flight");

  a_addr_stable: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (rom_req_i && !rom_gnt_i) |=> $stable(rom_addr_i))
    else $error("rom_addr_o changed while a request was pending");

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    fifo_count_i <= 3'(DEPTH))
    else $error("instruction buffer overflow");
endmodule

module ifetch #(
  parameter int unsigned DEPTH      = 2,
  parameter logic [15:0] RESET_ADDR = 16'h0000
) (
  input logic      clk_i,
  input logic      reset_n_i,
  ifetch_if.master bus
);
  localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [3:0]       DEPTH_C  = 4'(DEPTH);

  typedef struct packed {
    logic [15:0] data;
    logic [15:0] pc;
  } entry_t;

  entry_t           mem_q [2**PTR_W];
  logic [15:0]      fetch_addr_q, fetch_addr_d;
  logic [15:0]      resp_pc_q, resp_pc_d;
  logic [2:0]       in_flight_q, in_flight_d;
  logic [2:0]       discard_q, discard_d;
  logic [2:0]       count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             accept_s, resp_s, pop_s, push_s, req_s;
  logic [3:0]       occupancy_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  // Outstanding grants reserve buffer slots, so the buffer can never overflow.
  assign occupancy_s = {1'b0, count_q} + {1'b0, in_flight_q};
  assign req_s       = reset_n_i & ~bus.redirect_i & (occupancy_s < DEPTH_C);
  assign accept_s    = req_s & bus.rom_gnt_i;
  assign resp_s      = bus.rom_rvalid_i & (in_flight_q != 3'd0);
  assign pop_s       = bus.instr_valid_o & bus.instr_ready_i;
  assign in_flight_d = in_flight_q + {2'b00, accept_s} - {2'b00, resp_s};

  assign bus.rom_req_o     = req_s;
  assign bus.rom_addr_o    = fetch_addr_q;
  assign bus.instr_valid_o = (count_q != 3'd0);
  assign bus.instr_o       = mem_q[rd_ptr_q].data;
  assign bus.instr_pc_o    = mem_q[rd_ptr_q].pc;

  // Next-state: redirect flushes the buffer and marks every outstanding response for discard.
  always_comb begin
    fetch_addr_d = fetch_addr_q;
    resp_pc_d    = resp_pc_q;
    discard_d    = discard_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    push_s       = 1'b0;
    if (bus.redirect_i) begin
      fetch_addr_d = bus.redirect_addr_i;
      resp_pc_d    = bus.redirect_addr_i;
      discard_d    = in_flight_q - {2'b00, resp_s};
      wr_ptr_d     = {PTR_W{1'b0}};
      rd_ptr_d     = {PTR_W{1'b0}};
      count_d      = 3'd0;
    end else begin
      if (accept_s) begin
        fetch_addr_d = fetch_addr_q + 16'd1;
      end else begin
        fetch_addr_d = fetch_addr_q;
      end
      if (resp_s && (discard_q != 3'd0)) begin
        discard_d = discard_q - 3'd1;
      end else if (resp_s) begin
        push_s    = 1'b1;
        resp_pc_d = resp_pc_q + 16'd1;
      end else begin
        discard_d = discard_q;
      end
      if (push_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + {2'b00, push_s} - {2'b00, pop_s};
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fetch_addr_q <= RESET_ADDR;
      resp_pc_q    <= RESET_ADDR;
      in_flight_q  <= 3'd0;
      discard_q    <= 3'd0;
      count_q      <= 3'd0;
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
    end else begin
      fetch_addr_q <= fetch_addr_d;
      resp_pc_q    <= resp_pc_d;
      in_flight_q  <= in_flight_d;
      discard_q    <= discard_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // Buffer storage; cleared on reset so the head outputs read zero.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < 2**PTR_W; i++) begin
        mem_q[i] <= {32{1'b0}};
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= '{data: bus.rom_rdata_i, pc: resp_pc_q};
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  ifetch_sva #(.DEPTH(DEPTH)) u_sva (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .rom_req_i    (req_s),
    .rom_gnt_i    (bus.rom_gnt_i),
    .rom_rvalid_i (bus.rom_rvalid_i),
    .rom_addr_i   (fetch_addr_q),
    .in_flight_i  (in_flight_q),
    .fifo_count_i (count_q)
  );
endmodule

// File: tb/tb_ifetch.sv
// Randomized bench for ifetch: a queue-based model of outstanding requests and buffered
// instructions is compared with the DUT every cycle, plus fixed scenario pins.
module tb_ifetch;
  localparam int          DEPTH      = 2;
  localparam logic [15:0] RESET_ADDR = 16'h0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  ifetch_if bus ();

  ifetch #(.DEPTH(DEPTH), .RESET_ADDR(RESET_ADDR)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] pc; logic [15:0] data; } ins_t;
  typedef struct { logic [15:0] addr; int due; } rsp_t;

  ins_t        buf_q[$];   // expected instruction buffer contents
  bit          infl_q[$];  // one entry per outstanding grant: 1 = will be discarded
  rsp_t        rom_q[$];   // ROM environment: pending responses in order
  ins_t        log_q[$];   // instructions consumed (per the model)
  logic [15:0] exp_fetch, exp_rpc;
  int          cyc = 0, last_due = 0;
  int          n_checks = 0, n_fail = 0;
  int          gnt_pct, rdy_pct, lat_lo, lat_hi;
  logic        redir;
  logic [15:0] raddr;

  function automatic logic [15:0] rom_fn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  task automatic chk1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] log_pc(input int i);
    return (log_q.size() > i) ? log_q[i].pc : 16'hDEAD;
  endfunction

  function automatic logic [15:0] log_data(input int i);
    return (log_q.size() > i) ? log_q[i].data : 16'hDEAD;
  endfunction

  task automatic model_reset();
    buf_q.delete();
    infl_q.delete();
    rom_q.delete();
    exp_fetch = RESET_ADDR;
    exp_rpc   = RESET_ADDR;
    last_due  = cyc;
  endtask

  // One clock cycle: drive at negedge, compare before posedge, advance model and ROM.
  task automatic step();
    logic rv, g, exp_req, exp_valid, pop;
    bit   fl;
    int   due;
    bus.redirect_i      = redir;
    bus.redirect_addr_i = raddr;
    bus.instr_ready_i   = ($urandom_range(99) < 32'(rdy_pct));
    rv = (rom_q.size() > 0) && (rom_q[0].due <= cyc);
    bus.rom_rvalid_i = rv;
    bus.rom_rdata_i  = rv ? rom_fn(rom_q[0].addr) : 16'($urandom);
    #1;
    g = bus.rom_req_o && ($urandom_range(99) < 32'(gnt_pct));
    bus.rom_gnt_i = g;
    #1;
    exp_req   = !redir && ((buf_q.size() + infl_q.size()) < DEPTH);
    exp_valid = (buf_q.size() != 0);
    chk1("rom_req", bus.rom_req_o, exp_req);
    chk16("rom_addr", bus.rom_addr_o, exp_fetch);
    chk1("instr_valid", bus.instr_valid_o, exp_valid);
    if (exp_valid) begin
      chk16("instr", bus.instr_o, buf_q[0].data);
      chk16("instr_pc", bus.instr_pc_o, buf_q[0].pc);
    end
    pop = exp_valid && bus.instr_ready_i;
    if (pop) begin
      log_q.push_back(buf_q[0]);
      void'(buf_q.pop_front());
    end
    fl = 1'b1;
    if (rv && infl_q.size() > 0) fl = infl_q.pop_front();
    if (redir) begin
      buf_q.delete();
      exp_fetch = raddr;
      exp_rpc   = raddr;
      foreach (infl_q[i]) infl_q[i] = 1'b1;
    end else begin
      if (rv && !fl) begin
        buf_q.push_back('{pc: exp_rpc, data: rom_fn(exp_rpc)});
        exp_rpc = exp_rpc + 16'd1;
      end
      if (g) begin
        infl_q.push_back(1'b0);
        exp_fetch = exp_fetch + 16'd1;
      end
    end
    if (rv) void'(rom_q.pop_front());
    if (g) begin
      due = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      rom_q.push_back('{addr: bus.rom_addr_o, due: due});
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic redirect_to(input logic [15:0] a);
    redir = 1'b1;
    raddr = a;
    step();
    redir = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1);
  end

  initial begin
    bool_init: begin
      bus.redirect_i = 1'b0; bus.redirect_addr_i = 16'h0000;
      bus.rom_gnt_i = 1'b0; bus.rom_rvalid_i = 1'b0; bus.rom_rdata_i = 16'h0000;
      bus.instr_ready_i = 1'b0;
    end
    redir = 1'b0; raddr = 16'h0000;
    gnt_pct = 100; rdy_pct = 100; lat_lo = 1; lat_hi = 1;
    model_reset();

    #3;
    chk1("rst_req", bus.rom_req_o, 1'b0);
    chk1("rst_valid", bus.instr_valid_o, 1'b0);
    chk16("rst_instr", bus.instr_o, 16'h0000);
    chk16("rst_pc", bus.instr_pc_o, 16'h0000);
    chk16("rst_addr", bus.rom_addr_o, RESET_ADDR);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk1("first_req", bus.rom_req_o, 1'b1);
    chk16("first_addr", bus.rom_addr_o, 16'h0000);

    // Straight-line fetch.
    log_q.delete();
    run(20);
    chk1("sl_count", log_q.size() >= 4, 1'b1);
    chk16("sl_pc0", log_pc(0), 16'h0000);
    chk16("sl_pc1", log_pc(1), 16'h0001);
    chk16("sl_pc2", log_pc(2), 16'h0002);
    chk16("sl_pc3", log_pc(3), 16'h0003);
    chk16("sl_data0", log_data(0), 16'h5A5A);

    // Backpressure.
    rdy_pct = 0;
    redirect_to(16'h0200);
    run(10);
    #1;
    chk1("bp_valid", bus.instr_valid_o, 1'b1);
    chk16("bp_head", bus.instr_pc_o, 16'h0200);
    chk1("bp_req", bus.rom_req_o, 1'b0);
    chk1("bp_model_full", buf_q.size() == DEPTH, 1'b1);
    log_q.delete();
    rdy_pct = 100;
    run(10);
    chk16("bp_pc0", log_pc(0), 16'h0200);
    chk16("bp_pc1", log_pc(1), 16'h0201);
    chk16("bp_pc2", log_pc(2), 16'h0202);

    // Redirect with two requests in flight.
    lat_lo = 3; lat_hi = 3;
    run(6);
    for (int i = 0; i < 20 && infl_q.size() != 2; i++) step();
    chk1("rd_two_inflight", infl_q.size() == 2, 1'b1);
    redirect_to(16'h0100);
    log_q.delete();
    run(15);
    chk16("rd_pc0", log_pc(0), 16'h0100);
    chk16("rd_data0", log_data(0), 16'h5A5B);

    // Redirect coinciding with a response and a pop.
    lat_lo = 1; lat_hi = 2;
    begin
      bit found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
        if (buf_q.size() > 0 && rom_q.size() > 0 && rom_q[0].due <= cyc) found = 1'b1;
        else step();
      end
      chk1("rp_found", found, 1'b1);
    end
    log_q.delete();
    redirect_to(16'h0300);
    chk1("rp_popped", log_q.size() == 1, 1'b1);
    log_q.delete();
    run(12);
    chk16("rp_pc0", log_pc(0), 16'h0300);
    chk16("rp_data0", log_data(0), 16'h5A59);

    // Address wrap.
    lat_lo = 1; lat_hi = 1;
    redirect_to(16'hFFFE);
    log_q.delete();
    run(15);
    chk16("wr_pc0", log_pc(0), 16'hFFFE);
    chk16("wr_pc1", log_pc(1), 16'hFFFF);
    chk16("wr_pc2", log_pc(2), 16'h0000);
    chk16("wr_pc3", log_pc(3), 16'h0001);
    chk16("wr_data1", log_data(1), 16'hA5A5);

    // Random traffic.
    gnt_pct = 60; rdy_pct = 60; lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 2000; i++) begin
      redir = ($urandom_range(99) < 5);
      raddr = 16'($urandom);
      step();
    end
    redir = 1'b0;

    // Asynchronous reset mid-operation.
    gnt_pct = 100; rdy_pct = 0; lat_lo = 4; lat_hi = 4;
    run(8);
    #1;
    chk1("ar_pre_valid", bus.instr_valid_o, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    chk1("ar_req", bus.rom_req_o, 1'b0);
    chk1("ar_valid", bus.instr_valid_o, 1'b0);
    chk16("ar_pc", bus.instr_pc_o, 16'h0000);
    bus.rom_gnt_i = 1'b0;
    bus.rom_rvalid_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk1("ar_first_req", bus.rom_req_o, 1'b1);
    chk16("ar_first_addr", bus.rom_addr_o, RESET_ADDR);
    model_reset();
    rdy_pct = 100; lat_lo = 1; lat_hi = 1;
    log_q.delete();
    run(10);
    chk16("ar_pc0", log_pc(0), RESET_ADDR);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
